cs_resolve_seq: RTL

- Converts a 130-digit redundant carry-save operand (C/S, 19-bit digits, radix 2^16) into canonical non-redundant 16-bit digits plus a top carry.
- It is the consumer end of the redundant accumulator outputs, typically placed before result export or final modular compare.
- It processes LANES digits per cycle with a registered inter-chunk carry, so a full conversion takes NUM_DIGITS/LANES cycles.
- It uses a valid/ready handshake on both sides.

---
 rtl/cs_resolve_seq_if.sv | 27 ++
 rtl/cs_resolve_seq.sv | 116 +++++++++++
 2 files changed

// File: rtl/cs_resolve_seq_if.sv
// Handshake bundle for cs_resolve_seq: operand intake (C/S vectors) and canonical result export.
interface cs_resolve_seq_if #(
    parameter int unsigned NUM_DIGITS = 130,
    parameter int unsigned DIGIT_W    = 19,
    parameter int unsigned BASE_W     = 16,
    parameter int unsigned CARRY_W    = 5
);
    logic                          in_valid;
    logic                          in_ready;
    logic [NUM_DIGITS*DIGIT_W-1:0] in_c;
    logic [NUM_DIGITS*DIGIT_W-1:0] in_s;
    logic                          out_valid;
    logic                          out_ready;
    logic [NUM_DIGITS*BASE_W-1:0]  out_z;
    logic [CARRY_W-1:0]            out_carry;
    logic                          busy;

    modport master (
        output in_valid, in_c, in_s, out_ready,
        input  in_ready, out_valid, out_z, out_carry, busy
    );

    modport slave (
        input  in_valid, in_c, in_s, out_ready,
        output in_ready, out_valid, out_z, out_carry, busy
    );
endinterface

// File: rtl/cs_resolve_seq.sv
// Carry-save to canonical radix-2^BASE_W converter; resolves LANES digits per cycle with a
// registered carry between chunks, so one operand takes NUM_DIGITS/LANES RUN cycles.
module cs_resolve_seq #(
    parameter int unsigned NUM_DIGITS = 130,
    parameter int unsigned DIGIT_W    = 19,
    parameter int unsigned BASE_W     = 16,
    parameter int unsigned LANES      = 10
) (
    input logic             clk,
    input logic             rst_n,
    cs_resolve_seq_if.slave bus
);
    localparam int unsigned CARRY_W = 5;
    localparam int unsigned NCHUNK  = NUM_DIGITS / LANES;
    localparam int unsigned K_W     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned T_W     = DIGIT_W + 2;
    localparam int unsigned CV_W    = NUM_DIGITS * DIGIT_W;
    localparam int unsigned Z_W     = NUM_DIGITS * BASE_W;

    generate
        if (NUM_DIGITS % LANES != 0) begin : g_bad_lanes
            $error("cs_resolve_seq: NUM_DIGITS must be a multiple of LANES");
        end
    endgenerate

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             r_state;
    logic [CV_W-1:0]    r_c;
    logic [CV_W-1:0]    r_s;
    logic [K_W-1:0]     r_k;
    logic [CARRY_W-1:0] r_cy;
    logic [CARRY_W-1:0] r_carry;
    logic [Z_W-1:0]     r_z;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;

    logic [LANES*DIGIT_W-1:0] w_c_chunk;
    logic [LANES*DIGIT_W-1:0] w_s_chunk;
    logic [LANES*BASE_W-1:0]  w_z_chunk;
    logic [CARRY_W-1:0]       w_cout;

    // Ripple the carry through the LANES digits of the current chunk.
    always_comb begin : c_ripple
        logic [CARRY_W-1:0] cin;
        logic [T_W-1:0]     t;
        w_c_chunk = r_c[32'(r_k) * LANES * DIGIT_W +: LANES * DIGIT_W];
        w_s_chunk = r_s[32'(r_k) * LANES * DIGIT_W +: LANES * DIGIT_W];
        w_z_chunk = '0;
        cin       = r_cy;
        t         = '0;
        for (int l = 0; l < LANES; l++) begin
            t = T_W'(w_c_chunk[l*DIGIT_W +: DIGIT_W]) + T_W'(w_s_chunk[l*DIGIT_W +: DIGIT_W])
                + T_W'(cin);
            w_z_chunk[l*BASE_W +: BASE_W] = t[BASE_W-1:0];
            cin = CARRY_W'(t >> BASE_W);
        end
        w_cout = cin;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_c         <= '0;
            r_s         <= '0;
            r_k         <= '0;
            r_cy        <= '0;
            r_carry     <= '0;
            r_z         <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_c        <= bus.in_c;
                        r_s        <= bus.in_s;
                        r_k        <= '0;
                        r_cy       <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= StRun;
                    end
                end
                StRun: begin
                    r_z[32'(r_k) * LANES * BASE_W +: LANES * BASE_W] <= w_z_chunk;
                    r_cy <= w_cout;
                    r_k  <= r_k + 1'b1;
                    if (r_k == K_W'(NCHUNK - 1)) begin
                        r_carry     <= w_cout;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= StDone;
                    end
                end
                StDone: begin
                    // in_ready only returns after the handshake edge: no same-cycle bypass.
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_z     = r_z;
    assign bus.out_carry = r_carry;
    assign bus.busy      = r_busy;
endmodule
